// File: rtl/pc_ctrl.sv
// Program-counter controller: increment, relative branch, absolute jump,
// call/return through a small LIFO return-address stack, sticky error flag.
module pc_ctrl #(
  parameter int                BITS       = 8,
  parameter int                DEPTH      = 4,
  parameter logic [BITS-1:0]   RESET_ADDR = '0,
  localparam int               DW         = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [1:0]      sel,
  input  logic            call,
  input  logic [BITS-1:0] offset,
  input  logic [BITS-1:0] target,
  input  logic            err_clr,
  output logic [BITS-1:0] pc,
  output logic [DW-1:0]   depth,
  output logic            full,
  output logic            empty,
  output logic            err
);

  localparam int IW = $clog2(DEPTH);

  localparam logic [1:0] SEL_INC = 2'b00;
  localparam logic [1:0] SEL_REL = 2'b01;
  localparam logic [1:0] SEL_ABS = 2'b10;
  localparam logic [1:0] SEL_RET = 2'b11;

  logic [BITS-1:0] pc_q, pc_d;
  logic [DW-1:0]   depth_q, depth_d;
  logic            err_q, err_d;
  logic [BITS-1:0] stack_q [DEPTH];
  logic [BITS-1:0] stack_d [DEPTH];

  logic            full_w, empty_w;
  logic [IW-1:0]   push_idx, top_idx;

  // full/empty come purely from the registered depth, so no input reaches an output.
  assign full_w   = (depth_q == DW'(DEPTH));
  assign empty_w  = (depth_q == '0);
  assign push_idx = IW'(depth_q);
  assign top_idx  = IW'(depth_q - DW'(1));

  always_comb begin
    pc_d    = pc_q;
    depth_d = depth_q;
    err_d   = err_q;
    stack_d = stack_q;

    // Clear first so that a same-cycle error below overrides it.
    if (err_clr) err_d = 1'b0;

    if (en) begin
      case (sel)
        SEL_INC: pc_d = pc_q + BITS'(1);
        SEL_REL: pc_d = pc_q + offset;
        SEL_ABS: begin
          if (call) begin
            if (full_w) begin
              err_d = 1'b1;
            end else begin
              stack_d[push_idx] = pc_q + BITS'(1);
              depth_d           = depth_q + DW'(1);
              pc_d              = target;
            end
          end else begin
            pc_d = target;
          end
        end
        SEL_RET: begin
          if (empty_w) begin
            err_d = 1'b1;
          end else begin
            pc_d    = stack_q[top_idx];
            depth_d = depth_q - DW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_ADDR;
      depth_q <= '0;
      err_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      depth_q <= depth_d;
      err_q   <= err_d;
    end
  end

  // Stack storage is not reset; entries at or above depth are never read.
  always_ff @(posedge clk) begin
    stack_q <= stack_d;
  end

  assign pc    = pc_q;
  assign depth = depth_q;
  assign full  = full_w;
  assign empty = empty_w;
  assign err   = err_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// Bench for pc_ctrl: directed scenarios plus random traffic, scored against
// a queue-based reference model of the call stack.
module tb_pc_ctrl;

  localparam int BITS  = 8;
  localparam int DEPTH = 4;
  localparam int DW    = $clog2(DEPTH + 1);
  localparam int W     = BITS + DW + 3;
  localparam logic [BITS-1:0] RST_PC = 8'h00;

  logic            clk;
  logic            rst_n;
  logic            en;
  logic [1:0]      sel;
  logic            call;
  logic [BITS-1:0] offset;
  logic [BITS-1:0] target;
  logic            err_clr;
  logic [BITS-1:0] pc;
  logic [DW-1:0]   depth;
  logic            full;
  logic            empty;
  logic            err;

  pc_ctrl #(.BITS(BITS), .DEPTH(DEPTH), .RESET_ADDR(RST_PC)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .sel     (sel),
    .call    (call),
    .offset  (offset),
    .target  (target),
    .err_clr (err_clr),
    .pc      (pc),
    .depth   (depth),
    .full    (full),
    .empty   (empty),
    .err     (err)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [BITS-1:0] m_pc;
  logic [BITS-1:0] m_stk[$];
  logic            m_err;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];

  function automatic logic [W-1:0] model_pack();
    logic [DW-1:0] d;
    d = DW'(m_stk.size());
    return {m_pc, d, (m_stk.size() == DEPTH), (m_stk.size() == 0), m_err};
  endfunction

  function automatic logic [W-1:0] dut_pack();
    return {pc, depth, full, empty, err};
  endfunction

  task automatic model_reset();
    m_pc  = RST_PC;
    m_stk.delete();
    m_err = 1'b0;
  endtask

  task automatic model_step(input logic e, input logic [1:0] s, input logic c,
                            input logic [BITS-1:0] o, input logic [BITS-1:0] t,
                            input logic clr);
    logic [BITS-1:0] ret;
    if (clr) m_err = 1'b0;
    if (e) begin
      if (s == 2'd0) begin
        m_pc = m_pc + 8'd1;
      end else if (s == 2'd1) begin
        m_pc = m_pc + o;
      end else if (s == 2'd2) begin
        if (!c) begin
          m_pc = t;
        end else if (m_stk.size() == DEPTH) begin
          m_err = 1'b1;
        end else begin
          ret = m_pc + 8'd1;
          m_stk.push_back(ret);
          m_pc = t;
        end
      end else begin
        if (m_stk.size() == 0) begin
          m_err = 1'b1;
        end else begin
          m_pc = m_stk.pop_back();
        end
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic e, input logic [1:0] s, input logic c,
                       input logic [BITS-1:0] o, input logic [BITS-1:0] t,
                       input logic clr);
    en = e; sel = s; call = c; offset = o; target = t; err_clr = clr;
    model_step(e, s, c, o, t, clr);
    exp_q.push_back(model_pack());
  endtask

  task automatic step(input logic e, input logic [1:0] s, input logic c,
                      input logic [BITS-1:0] o, input logic [BITS-1:0] t,
                      input logic clr);
    @(posedge clk);
    #2;
    drive(e, s, c, o, t, clr);
  endtask

  task automatic inc();                        step(1, 2'd0, 0, 8'h00, 8'h00, 0); endtask
  task automatic jmp(input logic [7:0] t);     step(1, 2'd2, 0, 8'h00, t, 0);     endtask
  task automatic cal(input logic [7:0] t);     step(1, 2'd2, 1, 8'h00, t, 0);     endtask
  task automatic br(input logic [7:0] o);      step(1, 2'd1, 0, o, 8'h00, 0);     endtask
  task automatic ret(input logic clr);         step(1, 2'd3, 0, 8'h00, 8'h00, clr); endtask

  task automatic check_now(input string name);
    logic [W-1:0] a, x;
    a = dut_pack();
    x = model_pack();
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s: got pc=%h depth=%0d full=%b empty=%b err=%b, want pc=%h depth=%0d full=%b empty=%b err=%b",
               name, a[W-1 -: BITS], a[DW+2:3], a[2], a[1], a[0],
               x[W-1 -: BITS], x[DW+2:3], x[2], x[1], x[0]);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  int step_no = 0;
  always @(posedge clk) begin
    logic [W-1:0] a, x;
    #1;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      a = dut_pack();
      checks++;
      step_no++;
      if (a !== x) begin
        errors++;
        $display("FAIL step%0d: got pc=%h depth=%0d full=%b empty=%b err=%b, want pc=%h depth=%0d full=%b empty=%b err=%b",
                 step_no, a[W-1 -: BITS], a[DW+2:3], a[2], a[1], a[0],
                 x[W-1 -: BITS], x[DW+2:3], x[2], x[1], x[0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; en = 1'b0; sel = 2'd0; call = 1'b0;
    offset = '0; target = '0; err_clr = 1'b0;
    model_reset();
    #1;
    check_now("reset_state");

    // Release between edges with an increment already presented: first edge counts.
    #11;
    rst_n = 1'b1;
    drive(1, 2'd0, 0, 8'h00, 8'h00, 0);
    inc(); inc();

    // Wrap 0xFF -> 0x00.
    jmp(8'hFF); inc();

    // Relative branches and hold.
    jmp(8'h10); br(8'hF0);
    jmp(8'h10); br(8'h05);
    step(0, 2'd0, 0, 8'h00, 8'h00, 0);
    step(0, 2'd3, 1, 8'h00, 8'h77, 0);
    // call ignored outside sel=10
    step(1, 2'd0, 1, 8'h00, 8'h99, 0);
    step(1, 2'd1, 1, 8'h02, 8'h99, 0);

    // Nested call / return.
    jmp(8'h20); cal(8'h40); cal(8'h60); ret(0); ret(0);

    // Overflow, then clear together with a return.
    cal(8'h01); cal(8'h02); cal(8'h03); cal(8'h04);
    cal(8'h05);
    ret(1);
    ret(0); ret(0); ret(0);

    // Underflow; clear in the same cycle as a second underflow keeps err.
    ret(0); ret(1);
    // Clear honoured while disabled.
    step(0, 2'd0, 0, 8'h00, 8'h00, 1);

    // Asynchronous reset between edges after two calls.
    jmp(8'h30); cal(8'h50); cal(8'h70);
    @(posedge clk);
    #3;
    en = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_now("async_reset");
    #3;
    rst_n = 1'b1;
    ret(0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic       e, c, clr;
      logic [1:0] s;
      e   = ($urandom_range(0, 9) != 0);
      s   = 2'($urandom_range(0, 3));
      c   = ($urandom_range(0, 2) != 0);
      clr = ($urandom_range(0, 7) == 0);
      step(e, s, c, 8'($urandom), 8'($urandom), clr);
    end

    @(posedge clk);
    #5;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
